// File: rtl/cnn_mac_pkg.sv
// Shared types and constants for the CNN multiply-accumulate output stage.
package cnn_mac_pkg;

    localparam int PROD_W  = 20;
    localparam int OUT_W   = 14;
    localparam int BIAS_W  = 14;
    localparam int OUT_MAX = 8191;
    localparam int OUT_MIN = -8192;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/cnn_mac_requant.sv
// Combinational requantizer: round half up, arithmetic shift, saturate to 14 bits.
// Optional ReLU clamp of negative results under macro CNN_MAC_RELU_EN.
module cnn_mac_requant
    import cnn_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SHIFT     = 6
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_W-1:0]     res,
    output logic                        sat
);

    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) <<< (SHIFT-1);
    localparam logic signed [ACC_WIDTH:0] HI   = (ACC_WIDTH+1)'(OUT_MAX);
    localparam logic signed [ACC_WIDTH:0] LO   = (ACC_WIDTH+1)'(OUT_MIN);

    // One extra bit so adding the rounding constant can never wrap.
    function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] t;
        t = {a[ACC_WIDTH-1], a} + HALF;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_WIDTH:0] v);
        if (v > HI)
            return {1'b1, OUT_W'(OUT_MAX)};
        else if (v < LO)
            return {1'b1, OUT_W'(OUT_MIN)};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic signed [ACC_WIDTH:0] shifted;
    logic [OUT_W:0]            sat_res;

    always_comb begin
        shifted = round_shift(acc);
        sat_res = saturate(shifted);
        res     = sat_res[OUT_W-1:0];
        sat     = sat_res[OUT_W];
`ifdef CNN_MAC_RELU_EN
        if (sat_res[OUT_W-1]) begin
            res = '0;
            sat = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/cnn_mac_accum.sv
// Accumulates NTERMS products plus a pre-scaled bias, then holds a requantized
// 14-bit result until accepted. Optional ReLU via macro CNN_MAC_RELU_EN.
module cnn_mac_accum
    import cnn_mac_pkg::*;
#(
    parameter int NTERMS    = 25,
    parameter int SHIFT     = 6,
    parameter int ACC_WIDTH = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_dat,
    input  logic                     prod_vld,
    output logic                     prod_rdy,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  out_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     sat_flag,
    output logic                     busy
);

    localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc_p0;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic signed [OUT_W-1:0]     rq_dat;
    logic                        rq_sat;
    logic                        accept;
    logic                        last;

    assign prod_rdy = (state == ST_ACC) && !ap_rst;
    assign accept   = prod_vld && prod_rdy;
    assign last     = (cnt == CNT_W'(NTERMS-1));
    assign busy     = (cnt != '0) || out_vld;

    // Stage 0: the first term seeds the accumulator with the scaled bias.
    always_comb begin
        if (cnt == '0)
            acc_nxt = (ACC_WIDTH'(bias) <<< SHIFT) + ACC_WIDTH'(prod_dat);
        else
            acc_nxt = acc_p0 + ACC_WIDTH'(prod_dat);
    end

    cnn_mac_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc (acc_nxt),
        .res (rq_dat),
        .sat (rq_sat)
    );

    // Stage 1: result register, loaded on the edge that completes the sum.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= ST_ACC;
            cnt      <= '0;
            acc_p0   <= '0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc_p0 <= acc_nxt;
                        if (last) begin
                            cnt      <= '0;
                            state    <= ST_HOLD;
                            out_vld  <= 1'b1;
                            out_dat  <= rq_dat;
                            sat_flag <= rq_sat;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_rdy) begin
                        state   <= ST_ACC;
                        out_vld <= 1'b0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mac_accum.sv
// Self-checking bench for cnn_mac_accum with NTERMS=3, SHIFT=2; honours CNN_MAC_RELU_EN.
module tb_cnn_mac_accum;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [19:0] prod_dat = '0;
    logic               prod_vld = 1'b0;
    logic               prod_rdy;
    logic signed [13:0] bias = '0;
    logic signed [13:0] out_dat;
    logic               out_vld;
    logic               out_rdy = 1'b0;
    logic               sat_flag;
    logic               busy;

    int total = 0;
    int bad   = 0;

    cnn_mac_accum #(.NTERMS(3), .SHIFT(2), .ACC_WIDTH(32)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .prod_dat (prod_dat),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .bias     (bias),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .sat_flag (sat_flag),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string nm;
        int    b;
        int    p0;
        int    p1;
        int    p2;
        int    exp_d;
        int    exp_s;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: real-valued round half up of acc/4, then clamp (and optional ReLU).
    function automatic void model(input int b, input int p0, input int p1, input int p2,
                                  output int d, output int s);
        longint acc, num, q;
        acc = longint'(b) * 4 + p0 + p1 + p2;
        num = acc + 2;
        q   = num / 4;
        if ((num % 4 != 0) && (num < 0)) q = q - 1;
        s = 0;
        if (q > 8191)  begin q = 8191;  s = 1; end
        if (q < -8192) begin q = -8192; s = 1; end
`ifdef CNN_MAC_RELU_EN
        if (q < 0) begin q = 0; s = 0; end
`endif
        d = int'(q);
    endfunction

    function automatic void relu_adj(inout int d, inout int s);
`ifdef CNN_MAC_RELU_EN
        if (d < 0) begin d = 0; s = 0; end
`endif
    endfunction

    task automatic send(input int b, input int p);
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!prod_rdy && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (!prod_rdy) begin
            chk("prod_rdy timeout", 0, 1);
            return;
        end
        bias     = 14'(b);
        prod_dat = 20'(p);
        prod_vld = 1'b1;
        @(posedge ap_clk);
        #1;
        prod_vld = 1'b0;
    endtask

    task automatic release_out();
        @(negedge ap_clk);
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        out_rdy = 1'b0;
        chk("released out_vld", out_vld, 0);
        chk("released prod_rdy", prod_rdy, 1);
    endtask

    task automatic txn(input string nm, input int b, input int p0, input int p1, input int p2,
                       input int exp_d, input int exp_s, input int hold_cyc);
        send(b, p0);
        chk({nm, " vld after t0"}, out_vld, 0);
        chk({nm, " busy after t0"}, busy, 1);
        send(int'($urandom_range(0, 16383)) - 8192, p1);
        chk({nm, " vld after t1"}, out_vld, 0);
        send(int'($urandom_range(0, 16383)) - 8192, p2);
        chk({nm, " vld"}, out_vld, 1);
        chk({nm, " dat"}, out_dat, exp_d);
        chk({nm, " sat"}, sat_flag, exp_s);
        chk({nm, " rdy in hold"}, prod_rdy, 0);
        repeat (hold_cyc) @(posedge ap_clk);
        #1;
        if (hold_cyc > 0) chk({nm, " dat held"}, out_dat, exp_d);
        release_out();
    endtask

    vec_t vecs[$];

    initial begin
        int d, s;
        logic signed [13:0] held;

        vecs.push_back('{"basic",    1, 4, 8, -2, 4, 0});
        vecs.push_back('{"possat",   0, 131071, 131071, 131071, 8191, 1});
        vecs.push_back('{"neg",      0, -100, -100, -100, -75, 0});
        vecs.push_back('{"negsat",   -8192, -131072, -131072, -131072, -8192, 1});
        vecs.push_back('{"halfup",   0, 1, 1, 0, 1, 0});
        vecs.push_back('{"halfneg",  0, -1, -1, 0, 0, 0});
        vecs.push_back('{"roundneg", 0, -1, -1, -1, -1, 0});
        vecs.push_back('{"edge_max", 2047, 1, 1, 1, 2048, 0});

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst out_vld", out_vld, 0);
        chk("rst out_dat", out_dat, 0);
        chk("rst sat", sat_flag, 0);
        chk("rst prod_rdy", prod_rdy, 0);
        chk("rst busy", busy, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("post-rst prod_rdy", prod_rdy, 1);

        foreach (vecs[i]) begin
            d = vecs[i].exp_d;
            s = vecs[i].exp_s;
            relu_adj(d, s);
            txn(vecs[i].nm, vecs[i].b, vecs[i].p0, vecs[i].p1, vecs[i].p2, d, s, 0);
        end

        // Long hold with ignored product pulses
        d = 4; s = 0;
        send(1, 4); send(-77, 8); send(300, -2);
        chk("hold vld", out_vld, 1);
        held = out_dat;
        chk("hold dat", held, d);
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            prod_vld = k[0];
            prod_dat = 20'($urandom);
            bias     = 14'($urandom);
            chk("hold rdy low", prod_rdy, 0);
            @(posedge ap_clk);
            #1;
            chk("hold dat stable", out_dat, held);
            chk("hold vld stable", out_vld, 1);
            chk("hold sat stable", sat_flag, 0);
        end
        prod_vld = 1'b0;
        release_out();
        chk("after hold busy", busy, 0);
        txn("post-hold", 0, 4, 4, 4, 3, 0, 0);

        // Reset mid-accumulation
        send(5, 100); send(-3, 200);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        chk("midrst out_vld", out_vld, 0);
        chk("midrst out_dat", out_dat, 0);
        chk("midrst prod_rdy", prod_rdy, 0);
        chk("midrst busy", busy, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        txn("after midrst", 0, 4, 4, 4, 3, 0, 0);

        // Reset while holding a result
        send(0, 131071); send(0, 131071); send(0, 131071);
        chk("pre-rst hold sat", sat_flag, 1);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        chk("holdrst out_vld", out_vld, 0);
        chk("holdrst sat", sat_flag, 0);
        chk("holdrst out_dat", out_dat, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        txn("after holdrst", 1, 4, 8, -2, 4, 0, 0);

        // Randomized transactions against the model
        for (int t = 0; t < 30; t++) begin
            int b, p0, p1, p2;
            b  = int'($urandom_range(0, 16383)) - 8192;
            if (t % 3 == 0) begin
                p0 = int'($urandom_range(0, 1048575)) - 524288;
                p1 = int'($urandom_range(0, 1048575)) - 524288;
                p2 = int'($urandom_range(0, 1048575)) - 524288;
            end else begin
                p0 = int'($urandom_range(0, 4000)) - 2000;
                p1 = int'($urandom_range(0, 4000)) - 2000;
                p2 = int'($urandom_range(0, 4000)) - 2000;
            end
            model(b, p0, p1, p2, d, s);
            txn("rand", b, p0, p1, p2, d, s, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_mac_accum.md
CNN_MAC_ACCUM -- requirements
Module: cnn_mac_accum

Interface
REQ-001 SHALL have parameter NTERMS, default 25, giving the number of products per output (5x5 kernel); legal range 1..1024.
REQ-002 SHALL have parameter SHIFT, default 6, giving the fractional bits removed on requantization; legal range 1..12.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, giving the signed accumulator width; it must be at least 20+clog2(NTERMS)+1 and at least 15+SHIFT.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ap_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port prod_dat, input, 20 bits signed: product from the upstream 14s x 6s multiplier.
REQ-007 SHALL have port prod_vld, input, 1 bit: prod_dat is valid.
REQ-008 SHALL have port prod_rdy, output, 1 bit: the block accepts prod_dat this cycle.
REQ-009 SHALL have port bias, input, 14 bits signed: sampled only with the first product of each output.
REQ-010 SHALL have port out_dat, output, 14 bits signed: requantized result.
REQ-011 SHALL have port out_vld, output, 1 bit: out_dat is valid.
REQ-012 SHALL have port out_rdy, input, 1 bit: downstream accepts out_dat.
REQ-013 SHALL have port sat_flag, output, 1 bit: out_dat was clipped; valid only with out_vld.
REQ-014 SHALL have port busy, output, 1 bit: high when term count is nonzero or out_vld is high.

Function
REQ-015 SHALL have two states. In ACC, prod_rdy is 1 and out_vld is 0. In HOLD, prod_rdy is 0 and out_vld is 1.
REQ-016 SHALL treat a product as accepted only on a cycle where prod_vld and prod_rdy are both 1; a cycle with prod_vld=0 changes nothing.
REQ-017 On the first accepted term (cnt==0), SHALL load acc = sext(bias)<<SHIFT + sext(prod_dat).
REQ-018 On each later accepted term, SHALL load acc = acc + sext(prod_dat).
REQ-019 SHALL increment cnt on each accepted term and wrap it to 0 on accepting term NTERMS; that same edge moves ACC to HOLD.
REQ-020 SHALL register out_dat and sat_flag on the edge that moves ACC to HOLD, so out_vld rises one cycle after the last accepting edge.
REQ-021 SHALL compute out_dat = sat14((acc_final + 2^(SHIFT-1)) >>> SHIFT): round half up, then arithmetic shift.
REQ-022 SHALL saturate to the range -8192..8191 and set sat_flag=1 when clipping occurs.
REQ-023 SHALL hold out_dat, out_vld and sat_flag stable while out_rdy=0.
REQ-024 SHALL move HOLD to ACC on out_rdy=1, and the next product cannot be accepted before the following cycle; sustained throughput is one output per NTERMS+1 cycles.
REQ-025 With NTERMS=1, SHALL apply REQ-017 and enter HOLD on every accepted term.
REQ-026 SHALL ignore bias on every term except the first.

Reset
REQ-027 While ap_rst=1, SHALL force state=ACC, cnt=0, acc=0, out_dat=0, out_vld=0, sat_flag=0; prod_rdy=1 only after ap_rst is released.
REQ-028 SHALL discard any partial accumulation or held output when reset is asserted mid-operation, with no residue in the next result.

Configuration
REQ-029 SHALL support macro CNN_MAC_RELU_EN. When defined, a negative saturated result outputs 0 with sat_flag=0. When undefined, negative results pass through unchanged.

Structure
REQ-030 SHALL place the state enum, constants OUT_MAX=8191 and OUT_MIN=-8192, and widths 20/14 in shared package cnn_mac_pkg.
REQ-031 SHALL implement round, shift, saturate and optional ReLU as combinational sub-module cnn_mac_requant, instantiated once.

Verification (bench parameters NTERMS=3, SHIFT=2)
REQ-032 bias=1, products 4, 8, -2 -> acc 14; out_dat=4, sat_flag=0; out_vld one cycle after the third accept.
REQ-033 bias=0, products 131071 x3 -> out_dat=8191, sat_flag=1.
REQ-034 bias=0, products -100 x3 -> out_dat=-75 without the macro; out_dat=0 with CNN_MAC_RELU_EN.
REQ-035 Result held with out_rdy=0 for 5 cycles -> out_dat constant, prod_rdy=0, and prod_vld pulses during the hold are ignored.
REQ-036 ap_rst asserted after 2 terms, then bias=0 and products 4, 4, 4 -> out_dat=3 (12+2>>2), and outputs read 0 during reset.
